// File: rtl/rotary_encoder_pkg.sv
// Shared types and phase tables for the rotary encoder emulator.
// Pin pairs are packed {a,b}; the fourth phase of each table is the idle level.
package rotary_encoder_pkg;

    typedef enum logic [2:0] {
        IDLE_E,
        P1_E,
        P2_E,
        P3_E,
        P4_E,
        DONE_E
    } state_t;

    typedef logic [1:0] pins_t;

    localparam pins_t PINS_IDLE_C = 2'b11;

    localparam pins_t RIGHT_PHASES_C [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    localparam pins_t LEFT_PHASES_C  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

    // Non-phase states always present the idle level.
    function automatic pins_t phase_pins(input state_t s, input logic dir_right);
        logic [1:0] idx;
        idx = 2'd0;
        case (s)
            P1_E:    idx = 2'd0;
            P2_E:    idx = 2'd1;
            P3_E:    idx = 2'd2;
            P4_E:    idx = 2'd3;
            default: return PINS_IDLE_C;
        endcase
        return dir_right ? RIGHT_PHASES_C[idx] : LEFT_PHASES_C[idx];
    endfunction

endpackage

// File: rtl/rotary_encoder_emulator.sv
// Quadrature waveform generator emulating a mechanical rotary encoder.
// Accepts "N detents in direction D" commands and drives registered A/B pins.
module rotary_encoder_emulator #(
    parameter int PHASE_CYCLES_P = 4,
    parameter int STEPS_WIDTH_P  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_direction,
    input  logic [STEPS_WIDTH_P-1:0] cmd_steps,
    output logic                     encoder_pin_a,
    output logic                     encoder_pin_b,
    output logic                     busy,
    output logic                     done
);
    import rotary_encoder_pkg::*;

    localparam int TIMER_W = $clog2(PHASE_CYCLES_P);
    localparam logic [TIMER_W-1:0] TIMER_LOAD_C = TIMER_W'(PHASE_CYCLES_P - 1);
    localparam logic [STEPS_WIDTH_P-1:0] STEP_ONE_C = STEPS_WIDTH_P'(1);

    state_t                   state_q, state_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [STEPS_WIDTH_P-1:0] steps_q, steps_d;
    logic                     dir_q, dir_d;
    pins_t                    pins_q, pins_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        steps_d = steps_q;
        dir_d   = dir_q;

        case (state_q)
            IDLE_E: begin
                if (cmd_valid) begin
                    dir_d   = cmd_direction;
                    steps_d = cmd_steps;
                    timer_d = TIMER_LOAD_C;
                    state_d = (cmd_steps == '0) ? DONE_E : P1_E;
                end
            end
            P1_E, P2_E, P3_E, P4_E: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    timer_d = TIMER_LOAD_C;
                    case (state_q)
                        P1_E:    state_d = P2_E;
                        P2_E:    state_d = P3_E;
                        P3_E:    state_d = P4_E;
                        default: begin
                            // The count never wraps: it only moves while nonzero.
                            if (steps_q != '0) begin
                                steps_d = steps_q - STEP_ONE_C;
                            end
                            state_d = (steps_q > STEP_ONE_C) ? P1_E : DONE_E;
                        end
                    endcase
                end
            end
            DONE_E:  state_d = IDLE_E;
            default: state_d = IDLE_E;
        endcase

        // Outputs are registered from the next state so they line up with it.
        pins_d  = phase_pins(state_d, dir_d);
        ready_d = (state_d == IDLE_E);
        busy_d  = (state_d inside {P1_E, P2_E, P3_E, P4_E});
        done_d  = (state_d == DONE_E);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_E;
            timer_q <= '0;
            steps_q <= '0;
            pins_q  <= PINS_IDLE_C;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            steps_q <= steps_d;
            pins_q  <= pins_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Direction is only consulted while a command runs, so it needs no reset.
    always_ff @(posedge clk) begin
        dir_q <= dir_d;
    end

    assign cmd_ready     = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign encoder_pin_a = pins_q[1];
    assign encoder_pin_b = pins_q[0];

endmodule

// File: tb/tb_rotary_encoder_emulator.sv
// Directed bench for rotary_encoder_emulator with a scoreboard and a loopback
// quadrature decoder model that counts detents from the pin waveform.
module tb_rotary_encoder_emulator;

    localparam int PHASE = 4;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_direction = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic          cmd_ready;
    logic          encoder_pin_a;
    logic          encoder_pin_b;
    logic          busy;
    logic          done;

    rotary_encoder_emulator #(
        .PHASE_CYCLES_P (PHASE),
        .STEPS_WIDTH_P  (SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_direction (cmd_direction),
        .cmd_steps     (cmd_steps),
        .encoder_pin_a (encoder_pin_a),
        .encoder_pin_b (encoder_pin_b),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int done_cyc;
        int right;
        int left;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Loopback decoder + scoreboard monitor.
    logic [1:0] pins_now;
    logic [1:0] prev;
    logic       first_right;
    int         cnt_r, cnt_l, base_r, base_l;
    int         illegal  = 0;
    int         done_cnt = 0;
    exp_t       mon_e;

    assign pins_now = {encoder_pin_a, encoder_pin_b};

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        = 2'b11;
            first_right = 1'b0;
            cnt_r       = 0;
            cnt_l       = 0;
            base_r      = 0;
            base_l      = 0;
            exp_q.delete();
        end else begin
            if (pins_now != prev) begin
                if (pins_now[1] != prev[1] && pins_now[0] != prev[0]) illegal++;
                if (prev == 2'b11) first_right = (pins_now == 2'b10);
                if (pins_now == 2'b11) begin
                    if (first_right) cnt_r++;
                    else cnt_l++;
                end
                prev = pins_now;
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("right_detents", cnt_r - base_r, mon_e.right);
                    check("left_detents", cnt_l - base_l, mon_e.left);
                    check("done_busy", int'(busy), 0);
                    check("done_ready", int'(cmd_ready), 0);
                    check("done_pins", int'(pins_now), 3);
                    base_r = cnt_r;
                    base_l = cnt_l;
                end
            end
        end
    end

    task automatic send(input logic dir, input int steps, input int lat,
                        input int er, input int el, input bit hold, output int acc);
        exp_t e;
        cmd_valid     = 1'b1;
        cmd_direction = dir;
        cmd_steps     = SW'(steps);
        acc           = -1;
        for (int n = 0; n < 3000; n++) begin
            if (cmd_ready) begin
                acc        = cyc;
                e.done_cyc = cyc + lat;
                e.right    = er;
                e.left     = el;
                exp_q.push_back(e);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        int dc;
        int trace [16];
        trace = '{2, 2, 2, 2, 0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3};

        repeat (3) @(negedge clk);
        check("reset_pins", int'(pins_now), 3);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_pins", int'(pins_now), 3);
        check("idle_ready", int'(cmd_ready), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_detents", cnt_r + cnt_l, 0);
        check("idle_done_count", done_cnt, 0);

        // One detent right with a cycle-by-cycle pin trace.
        send(1'b1, 1, 17, 1, 0, 1'b0, acc1);
        for (int k = 0; k < 16; k++) begin
            check("trace_pins", int'(pins_now), trace[k]);
            check("trace_busy", int'(busy), 1);
            check("trace_ready", int'(cmd_ready), 0);
            @(negedge clk);
        end
        drain();

        send(1'b0, 5, 81, 0, 5, 1'b0, acc1);
        drain();

        // Zero steps: done on the next cycle, pins stay idle.
        send(1'b1, 0, 1, 0, 0, 1'b0, acc1);
        check("zero_pins", int'(pins_now), 3);
        check("zero_busy", int'(busy), 0);
        drain();

        // Back-to-back with cmd_valid held; second command's inputs change while busy.
        send(1'b1, 3, 49, 3, 0, 1'b1, acc1);
        send(1'b0, 2, 33, 0, 2, 1'b0, acc2);
        check("b2b_accept_gap", acc2 - acc1, 50);
        drain();

        // Reset in the middle of P2 of a 10-detent command.
        send(1'b1, 10, 161, 10, 0, 1'b0, acc1);
        repeat (5) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_pins", int'(pins_now), 0);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midreset_pins", int'(pins_now), 3);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(cmd_ready), 1);
        check("midreset_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("no_done_after_reset", done_cnt, dc);
        check("post_reset_detents", cnt_r + cnt_l, 0);

        send(1'b1, 1, 17, 1, 0, 1'b0, acc1);
        drain();

        check("illegal_toggles", illegal, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
